// File: rtl/snes_pkg.sv
// Shared definitions for the SNES gamepad reader: report geometry,
// button bit positions inside snes_data, and the frame FSM encoding.
package snes_pkg;

  localparam int SNES_BITS = 16;
  localparam int SNES_BTNS = 12;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_GAP   = 3'd2,
    ST_LOW   = 3'd3,
    ST_HIGH  = 3'd4,
    ST_DONE  = 3'd5
  } snes_state_t;

endpackage

// File: rtl/snes_controller_reader_if.sv
// Pad side (latch/clk/serial) and CPU side (buttons, valid, connected)
// of the SNES reader. master = the reader, slave = pad + CPU.
interface snes_controller_reader_if;

  logic                           snes_serial;
  logic                           snes_latch;
  logic                           snes_clk;
  logic [snes_pkg::SNES_BTNS-1:0] snes_data;
  logic                           data_valid;
  logic                           connected;

  modport master (
    input  snes_serial,
    output snes_latch,
    output snes_clk,
    output snes_data,
    output data_valid,
    output connected
  );

  modport slave (
    output snes_serial,
    input  snes_latch,
    input  snes_clk,
    input  snes_data,
    input  data_valid,
    input  connected
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages give metastability time to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_controller_reader.sv
// Autonomous SNES gamepad poller: pulses latch, clocks out 16 bits,
// publishes the first 12 as active-high buttons once per frame.
module snes_controller_reader
  import snes_pkg::*;
#(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic                      clk,
  input  logic                      reset,
  snes_controller_reader_if.master  bus
);

  localparam int HC_W = $clog2(2 * HALF_CYCLES);
  localparam int PC_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int BC_W = $clog2(SNES_BITS);

  localparam logic [HC_W-1:0] HC_HALF_LAST  = HC_W'(HALF_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_LATCH_LAST = HC_W'(2 * HALF_CYCLES - 1);
  localparam logic [PC_W-1:0] POLL_LAST     = PC_W'(POLL_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST       = BC_W'(SNES_BITS - 1);

  snes_state_t          state, next_state;
  logic [HC_W-1:0]      hc;
  logic [BC_W-1:0]      bc;
  logic [PC_W-1:0]      poll_cnt;
  logic                 poll_wrap;
  logic                 start_pend;
  logic                 hc_last;
  logic                 sample_en;
  logic                 serial_s;
  logic [SNES_BITS-1:0] shift;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.snes_serial),
    .q     (serial_s)
  );

  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign hc_last   = (state == ST_LATCH) ? (hc == HC_LATCH_LAST) : (hc == HC_HALF_LAST);
  assign sample_en = (state == ST_LOW) && (hc == '0);

  // Free-running poll timer; a wrap that lands mid-frame is remembered until IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt   <= '0;
      start_pend <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      if (state == ST_IDLE)
        start_pend <= 1'b0;
      else if (poll_wrap)
        start_pend <= 1'b1;
    end
  end

  // FSM state register with the half-period and bit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      hc    <= '0;
      bc    <= '0;
    end else begin
      state <= next_state;
      hc    <= (next_state != state) ? '0 : hc + 1'b1;
      if (state == ST_GAP)
        bc <= '0;
      else if ((state == ST_HIGH) && hc_last)
        bc <= bc + 1'b1;
    end
  end

  // Next-state logic for one latch/shift frame.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (poll_wrap || start_pend) next_state = ST_LATCH;
      ST_LATCH: if (hc_last) next_state = ST_GAP;
      ST_GAP:   if (hc_last) next_state = ST_LOW;
      ST_LOW:   if (hc_last) next_state = ST_HIGH;
      ST_HIGH:  if (hc_last) next_state = (bc == BC_LAST) ? ST_DONE : ST_LOW;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Capture each inverted bit on the falling edge of snes_clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      shift <= '0;
    else if (sample_en)
      shift[bc] <= ~serial_s;
  end

  // Registered pad and CPU outputs; pad lines follow the upcoming state so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.snes_latch <= 1'b0;
      bus.snes_clk   <= 1'b1;
      bus.snes_data  <= '0;
      bus.data_valid <= 1'b0;
      bus.connected  <= 1'b0;
    end else begin
      bus.snes_latch <= (next_state == ST_LATCH);
      bus.snes_clk   <= (next_state != ST_LOW);
      bus.data_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        bus.snes_data <= shift[BTN_R:BTN_B];
        bus.connected <= &(~shift[SNES_BITS-1:SNES_BTNS]);
      end
    end
  end

endmodule

// File: tb/tb_snes_controller_reader.sv
// Bench for snes_controller_reader: models the gamepad on the pad lines
// and checks every cycle against a frame-timing/report model.
`timescale 1ns/1ps
module tb_snes_controller_reader;

  localparam int HC      = 4;
  localparam int PC      = 200;
  localparam int DV_OFS  = 35 * HC + 1;

  logic clk;
  logic reset;

  snes_controller_reader_if bus ();

  snes_controller_reader #(.HALF_CYCLES(HC), .POLL_CYCLES(PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;

  logic [15:0] raw       = 16'hFFFE;
  logic        unplugged = 1'b0;
  logic        jitter_en = 1'b0;

  logic [15:0] ctrl_sr   = 16'hFFFF;
  logic        ctrl_bit  = 1'b1;
  logic        prev_sclk = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t e=%0d)", nm, act, exp, $time, e);
    end
  endtask

  // Gamepad: reloads while latch is high, shifts on each snes_clk rise.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.snes_latch)
        ctrl_sr = raw;
      else if (bus.snes_clk && !prev_sclk)
        ctrl_sr = {1'b1, ctrl_sr[15:1]};
      prev_sclk = bus.snes_clk;
      ctrl_bit  = ctrl_sr[0];
    end
  end

  // Data line with optional edge jitter; pull-down when unplugged.
  initial begin
    bus.snes_serial = 1'b0;
    forever begin
      @(ctrl_bit or unplugged);
      if (jitter_en) #($urandom_range(0, 19));
      bus.snes_serial = unplugged ? 1'b0 : ctrl_bit;
    end
  end

  // Cycle model: e counts clocks since reset release, frames start at multiples of PC.
  initial begin
    int p;
    logic [15:0] frame_raw;
    logic [11:0] exp_data;
    logic        exp_conn, exp_l, exp_c, exp_v;
    frame_raw = '0;
    exp_data  = '0;
    exp_conn  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        e = 0;
        exp_data = '0; exp_conn = 1'b0;
        exp_l = 1'b0; exp_c = 1'b1; exp_v = 1'b0;
      end else begin
        e++;
        p = e % PC;
        exp_l = (e >= PC) && (p < 2 * HC);
        exp_c = !((e >= PC) && (p >= 3 * HC) && (p < 35 * HC) && (((p - 3 * HC) % (2 * HC)) < HC));
        exp_v = (e >= PC + DV_OFS) && (p == DV_OFS);
        if ((e >= PC) && (p == 0)) frame_raw = unplugged ? 16'h0000 : raw;
        if (exp_v) begin
          exp_data = ~frame_raw[11:0];
          exp_conn = &frame_raw[15:12];
        end
      end
      chk("latch",     16'(bus.snes_latch), 16'(exp_l));
      chk("sclk",      16'(bus.snes_clk),   16'(exp_c));
      chk("valid",     16'(bus.data_valid), 16'(exp_v));
      chk("data",      16'(bus.snes_data),  16'(exp_data));
      chk("connected", 16'(bus.connected),  16'(exp_conn));
    end
  end

  task automatic wait_e(input int target);
    int guard;
    guard = 0;
    while (e < target) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        total++; bad++;
        $display("FAIL wait_e: reached %0d want %0d", e, target);
        break;
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_latch", 16'(bus.snes_latch), 16'h0);
    chk("rst_sclk",  16'(bus.snes_clk),   16'h1);
    chk("rst_data",  16'(bus.snes_data),  16'h000);
    reset = 1'b0;

    // First frame timing, raw FFFE: only B pressed, bits 12-15 high.
    wait_e(199); chk("lat_pre",  16'(bus.snes_latch), 16'h0);
    wait_e(200); chk("lat_rise", 16'(bus.snes_latch), 16'h1);
    wait_e(207); chk("lat_last", 16'(bus.snes_latch), 16'h1);
    wait_e(208); chk("lat_fall", 16'(bus.snes_latch), 16'h0);
    wait_e(212); chk("sclk_low", 16'(bus.snes_clk),   16'h0);
    wait_e(340); chk("dv_pre",   16'(bus.data_valid), 16'h0);
    wait_e(341); chk("dv_141",   16'(bus.data_valid), 16'h1);
    wait_e(350);
    chk("b_data", 16'(bus.snes_data), 16'h001);
    chk("b_conn", 16'(bus.connected), 16'h1);

    // A pressed.
    raw = 16'hFEFF;
    wait_e(550);
    chk("a_data", 16'(bus.snes_data), 16'h100);
    chk("a_conn", 16'(bus.connected), 16'h1);

    // B pressed but bits 12-15 low -> not connected.
    raw = 16'h0FFE;
    wait_e(750);
    chk("nc_data", 16'(bus.snes_data), 16'h001);
    chk("nc_conn", 16'(bus.connected), 16'h0);

    // Report changes during bit 6 of the frame at 800.
    raw = 16'hFFFF;
    wait_e(860);
    raw = 16'hFF00;
    wait_e(945);
    chk("stab_old", 16'(bus.snes_data), 16'h000);
    wait_e(1145);
    chk("stab_new", 16'(bus.snes_data), 16'h0FF);

    // Unplugged: pull-down everywhere.
    unplugged = 1'b1;
    wait_e(1350);
    chk("unp_data", 16'(bus.snes_data), 16'hFFF);
    chk("unp_conn", 16'(bus.connected), 16'h0);
    unplugged = 1'b0;

    // Jittered data edges.
    raw = 16'hF5A5;
    jitter_en = 1'b1;
    wait_e(1550);
    chk("jit_data", 16'(bus.snes_data), 16'hA5A);
    chk("jit_conn", 16'(bus.connected), 16'h1);

    // Reset during bit 9 of the frame at 1600.
    wait_e(1686);
    #2 reset = 1'b1;
    #1;
    chk("mid_latch", 16'(bus.snes_latch), 16'h0);
    chk("mid_sclk",  16'(bus.snes_clk),   16'h1);
    chk("mid_data",  16'(bus.snes_data),  16'h000);
    chk("mid_valid", 16'(bus.data_valid), 16'h0);
    chk("mid_conn",  16'(bus.connected),  16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_e(199); chk("re_lat_pre",  16'(bus.snes_latch), 16'h0);
    wait_e(200); chk("re_lat_rise", 16'(bus.snes_latch), 16'h1);
    wait_e(350);
    chk("re_data", 16'(bus.snes_data), 16'hA5A);
    chk("re_conn", 16'(bus.connected), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
